// File: rtl/ssb_mod_seq_if.sv
// Control/status bundle between the SSB sequencer and its controller.
// The master side drives requests and config; the slave side is the sequencer.
interface ssb_mod_seq_if #(
   parameter int PINC_W = 32
);
   logic              start;
   logic              stop;
   logic              in_valid;
   logic              cfg_we;
   logic [PINC_W-1:0] cfg_pinc;
   logic [PINC_W-1:0] pinc;
   logic              core_sclr;
   logic              dds_ce;
   logic              mul_ce;
   logic              add_ce;
   logic              out_valid;
   logic              busy;
   logic              cfg_err;

   modport master (
      output start, stop, in_valid, cfg_we, cfg_pinc,
      input  pinc, core_sclr, dds_ce, mul_ce, add_ce,
      input  out_valid, busy, cfg_err
   );

   modport slave (
      input  start, stop, in_valid, cfg_we, cfg_pinc,
      output pinc, core_sclr, dds_ce, mul_ce, add_ce,
      output out_valid, busy, cfg_err
   );
endinterface

// File: rtl/ssb_mod_seq.sv
// SSB datapath sequencer: clear -> prime -> run -> drain, with a
// result-aligned valid pipe and the session-locked DDS phase increment.
module ssb_mod_seq #(
   parameter int                DDS_LAT  = 6,
   parameter int                MUL_LAT  = 4,
   parameter int                ADD_LAT  = 2,
   parameter int                CLR_CYC  = 4,
   parameter int                PINC_W   = 32,
   parameter logic [PINC_W-1:0] PINC_RST = 32'h0100_0000
) (
   input logic          clk,
   input logic          rst,
   ssb_mod_seq_if.slave bus
);

   localparam int PL   = MUL_LAT + ADD_LAT;
   localparam int CM0  = (CLR_CYC > DDS_LAT) ? CLR_CYC : DDS_LAT;
   localparam int CMAX = (CM0 > PL) ? CM0 : PL;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_PRIME,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t            r_state;
   state_t            w_state;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt;
   logic [PL-1:0]     r_pipe;
   logic [PL-1:0]     w_pipe;
   logic [PINC_W-1:0] r_pinc;
   logic              r_sclr;
   logic              r_dds;
   logic              r_mul;
   logic              r_add;
   logic              r_busy;
   logic              r_err;
   logic              w_sclr;
   logic              w_dds;
   logic              w_mul;
   logic              w_add;
   logic              w_shift_in;
   logic              w_cnt_zero;

   assign w_cnt_zero = (r_cnt == '0);

   // Enables are computed for the next state so they land with it.
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_sclr  = 1'b0;
      w_dds   = 1'b0;
      w_mul   = 1'b0;
      w_add   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state = S_CLEAR;
               w_cnt   = CW'(CLR_CYC - 1);
               w_sclr  = 1'b1;
            end
         end
         S_CLEAR: begin
            if (bus.stop) begin
               w_state = S_IDLE;
               w_cnt   = '0;
            end else if (w_cnt_zero) begin
               w_state = S_PRIME;
               w_cnt   = CW'(DDS_LAT - 1);
               w_dds   = 1'b1;
            end else begin
               w_cnt  = r_cnt - 1'b1;
               w_sclr = 1'b1;
            end
         end
         S_PRIME: begin
            if (bus.stop) begin
               w_state = S_IDLE;
               w_cnt   = '0;
            end else if (w_cnt_zero) begin
               w_state = S_RUN;
               w_cnt   = '0;
               w_dds   = 1'b1;
               w_mul   = 1'b1;
               w_add   = 1'b1;
            end else begin
               w_cnt = r_cnt - 1'b1;
               w_dds = 1'b1;
            end
         end
         S_RUN: begin
            w_dds = 1'b1;
            w_mul = 1'b1;
            w_add = 1'b1;
            if (bus.stop) begin
               w_state = S_DRAIN;
               w_cnt   = CW'(PL - 1);
            end
         end
         S_DRAIN: begin
            if (w_cnt_zero) begin
               w_state = S_IDLE;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt - 1'b1;
               w_dds = 1'b1;
               w_mul = 1'b1;
               w_add = 1'b1;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_cnt   = '0;
         end
      endcase
   end

   assign w_shift_in = (r_state == S_RUN) && bus.in_valid;

   always_comb begin
      w_pipe = '0;
      if ((r_state == S_RUN || r_state == S_DRAIN) && w_state != S_IDLE)
         w_pipe = (r_pipe << 1) | PL'(w_shift_in);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pipe  <= '0;
         r_sclr  <= 1'b0;
         r_dds   <= 1'b0;
         r_mul   <= 1'b0;
         r_add   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_pipe  <= w_pipe;
         r_sclr  <= w_sclr;
         r_dds   <= w_dds;
         r_mul   <= w_mul;
         r_add   <= w_add;
         r_busy  <= (w_state != S_IDLE);
      end
   end

   // Phase increment is frozen for the whole session.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pinc <= PINC_RST;
         r_err  <= 1'b0;
      end else begin
         r_err <= bus.cfg_we && (r_state != S_IDLE);
         if (bus.cfg_we && r_state == S_IDLE)
            r_pinc <= bus.cfg_pinc;
      end
   end

   assign bus.pinc      = r_pinc;
   assign bus.core_sclr = r_sclr;
   assign bus.dds_ce    = r_dds;
   assign bus.mul_ce    = r_mul;
   assign bus.add_ce    = r_add;
   assign bus.out_valid = r_pipe[PL-1];
   assign bus.busy      = r_busy;
   assign bus.cfg_err   = r_err;

endmodule

// File: doc/ssb_mod_seq.md
# ssb_mod_seq

Sequencer for the single-sideband modulation datapath. The datapath computes hilbert×sin + delay×cos using the DDS sin/cos core, two multipliers and an adder. This block replaces free-running sticky clock enables with an explicit clear → prime → run → drain sequence. It generates a `result`-aligned `out_valid` and owns the DDS phase-increment register. It sits between the upstream Hilbert/delay filter stage and the carry datapath, and drives the cores' `ce` and `sclr` pins.

## Interface
Parameters:
- `DDS_LAT`, 6: DDS cycles from first `ce` to valid sine/cosine
- `MUL_LAT`, 4: multiplier pipeline depth (a/b to p)
- `ADD_LAT`, 2: adder pipeline depth (a/b to s)
- `CLR_CYC`, 4: cycles `core_sclr` is held during clear
- `PINC_W`, 32: phase-increment width
- `PINC_RST`, 32'h0100_0000: phase-increment reset value

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a session
- `stop`  in  1  single-cycle request to end a session
- `in_valid`  in  1  `g_t_hilbert`/`g_t_delay` pair valid this cycle
- `cfg_we`  in  1  write `cfg_pinc` into the phase register
- `cfg_pinc`  in  PINC_W  new phase increment
- `pinc`  out  PINC_W  phase increment to DDS
- `core_sclr`  out  1  synchronous clear to DDS, both multipliers, adder
- `dds_ce`  out  1  DDS clock enable
- `mul_ce`  out  1  both multipliers' clock enable
- `add_ce`  out  1  adder clock enable
- `out_valid`  out  1  `result` is a valid sample this cycle
- `busy`  out  1  state ≠ IDLE
- `cfg_err`  out  1  one-cycle pulse: `cfg_we` rejected

## Operation
- All outputs are registered. Reset values:
  - `pinc` = PINC_RST
  - all other outputs 0
  - state IDLE, counter 0, valid pipe cleared
- State IDLE:
  - all `ce` outputs and `core_sclr` are 0.
  - `start` → CLEAR.
  - `cfg_we` loads `pinc` <= `cfg_pinc`.
- State CLEAR:
  - `core_sclr` = 1 for exactly CLR_CYC cycles; the valid pipe is zeroed.
  - Then → PRIME.
- State PRIME:
  - `dds_ce` = 1 for exactly DDS_LAT cycles; `mul_ce` and `add_ce` are 0.
  - Then → RUN.
- State RUN:
  - `dds_ce`, `mul_ce` and `add_ce` are all 1.
  - The valid pipe, of length MUL_LAT+ADD_LAT, shifts in `in_valid` every cycle.
  - `out_valid` is the pipe's last stage.
  - `stop` → DRAIN.
- State DRAIN:
  - All `ce` outputs stay 1 and the pipe shifts in 0.
  - After MUL_LAT+ADD_LAT cycles → IDLE; `out_valid` = 0 from the IDLE cycle onward.
- `in_valid` is ignored in every state except RUN.
- `start` is ignored outside IDLE.
- `stop` behaviour:
  - in CLEAR or PRIME: abort → IDLE next cycle; all `ce` and `core_sclr` drop.
  - in IDLE or DRAIN: ignored.
- `start` and `stop` asserted in the same IDLE cycle: `start` wins.
- `cfg_we` outside IDLE:
  - `pinc` is unchanged and `cfg_err` pulses one cycle later.
  - This keeps phase continuity inside a session.
- A single down-counter, sized for max(CLR_CYC, DDS_LAT, MUL_LAT+ADD_LAT), times CLEAR, PRIME and DRAIN.
  - It is loaded on every state entry.
  - It is idle in IDLE and RUN.
- Reset asserted mid-session:
  - Immediate return to reset values, including `pinc`.
  - No drain; in-flight samples are discarded.

## Timing
- `start` sampled at edge 0 gives:
  - `core_sclr` high during cycles 1..CLR_CYC
  - `dds_ce` high from cycle CLR_CYC+1 (PRIME)
  - RUN from cycle CLR_CYC+DDS_LAT+1; with defaults, 11
- Latency: `in_valid` sampled in RUN at cycle t → `out_valid` at cycle t+MUL_LAT+ADD_LAT (defaults: t+6). This matches the `result` pipeline.
- Throughput: one sample per cycle; back-to-back `in_valid` gives back-to-back `out_valid`.
- `stop` sampled at cycle s in RUN:
  - DRAIN spans cycles s+1..s+MUL_LAT+ADD_LAT.
  - Every sample accepted up to and including cycle s appears on `out_valid`.
  - IDLE is entered at s+MUL_LAT+ADD_LAT+1.
- `busy` rises the cycle after `start` and falls on the IDLE-entry cycle.
- Minimum restart: `start` may be asserted in the first IDLE cycle.

## Test plan
- Reset with defaults:
  - Expect `pinc`=32'h0100_0000 and all other outputs 0.
  - Pulse `start` at cycle 0: `core_sclr` is high for cycles 1–4, `dds_ce` rises at 5, `mul_ce`/`add_ce` rise at 11, `busy`=1 from cycle 1.
- Pattern in RUN:
  - Drive `in_valid`=1,0,1,1 at cycles 12–15 → `out_valid`=1,0,1,1 at cycles 18–21.
  - A reference model of hilbert·sin+delay·cos matches `result` on each valid cycle.
- `stop` together with `in_valid`=1 at cycle 20:
  - That sample's `out_valid` appears at 26; `ce` outputs stay high through 26.
  - IDLE and `busy`=0 at 27; no `out_valid` after 26.
- `stop` at cycle 3 (CLEAR): IDLE at cycle 4, with `core_sclr`, `dds_ce` and `busy` all 0 at 4 and `dds_ce` never asserted.
- Configuration:
  - `cfg_we` with 32'h0200_0000 in IDLE → `pinc`=32'h0200_0000 next cycle.
  - The same write during RUN leaves `pinc` unchanged and gives a one-cycle `cfg_err` pulse.
- Reset asserted during RUN with valid samples in flight:
  - All outputs return to reset values immediately; no `out_valid` after reset.
  - A following `start` repeats the cycle-0 sequence exactly.
